// File: rtl/audio_volume.sv
// audio_volume: stereo attenuator (2 dB steps, 0..86 dB, mute), 2-cycle latency; optional gain ramping under `ifdef VOLUME_RAMP_EN
// Ports: clk; reset_n (async, active-low); sample_in_valid, sample_in[31:0] = {left, right} signed 16-bit;
//   lch_db, rch_db [5:0] attenuation codes (n -> 2n dB, >43 clamped); is_muted;
//   sample_out_valid (one strobe per frame), sample_out[31:0] (held between strobes).
module audio_volume (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sample_in_valid,
  input  logic [31:0] sample_in,
  input  logic [5:0]  lch_db,
  input  logic [5:0]  rch_db,
  input  logic        is_muted,
  output logic        sample_out_valid,
  output logic [31:0] sample_out
);
  localparam logic [5:0] MAX_CODE = 6'd43;
  function automatic logic [5:0] clamp(input logic [5:0] c);
    return c > MAX_CODE ? MAX_CODE : c;
  endfunction
  function automatic logic [31:0] scale(input logic [15:0] s, input logic [5:0] a);
    logic [1:0] r;
    logic [15:0] m;
    logic signed [32:0] p;
    r = 2'(a % 6'd3);
    m = r == 2'd0 ? 16'd32768 : r == 2'd1 ? 16'd26029 : 16'd20675;
    p = $signed(s) * $signed({1'b0, m});
    return p[31:0];
  endfunction
  function automatic logic [15:0] shift(input logic [31:0] p, input logic [3:0] q);
    return 16'($signed(p) >>> (5'd15 + 5'(q)));
  endfunction
  logic [5:0] a_l, a_r;
  logic       mute;
`ifdef VOLUME_RAMP_EN
  // Current codes walk one step per accepted frame toward the target; the frame uses the pre-step value.
  logic [5:0] c_l, c_r;
  function automatic logic [5:0] step(input logic [5:0] c, input logic [5:0] t);
    return c < t ? c + 6'd1 : c > t ? c - 6'd1 : c;
  endfunction
  assign a_l = c_l;
  assign a_r = c_r;
  assign mute = is_muted && c_l == MAX_CODE && c_r == MAX_CODE;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      c_l <= MAX_CODE;
      c_r <= MAX_CODE;
    end else if (sample_in_valid) begin
      c_l <= step(c_l, is_muted ? MAX_CODE : clamp(lch_db));
      c_r <= step(c_r, is_muted ? MAX_CODE : clamp(rch_db));
    end
`else
  assign a_l = clamp(lch_db);
  assign a_r = clamp(rch_db);
  assign mute = is_muted;
`endif
  // Capture stage freezes the frame with its gains and mute on the accept edge.
  logic        v0, m0, v1, m1;
  logic [31:0] d0, p_l, p_r;
  logic [5:0]  a_l0, a_r0;
  logic [3:0]  q_l, q_r;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      v0 <= 1'b0;
      m0 <= 1'b0;
      d0 <= '0;
      a_l0 <= MAX_CODE;
      a_r0 <= MAX_CODE;
      v1 <= 1'b0;
      m1 <= 1'b0;
      p_l <= '0;
      p_r <= '0;
      q_l <= '0;
      q_r <= '0;
      sample_out_valid <= 1'b0;
      sample_out <= '0;
    end else begin
      v0 <= sample_in_valid;
      if (sample_in_valid) begin
        d0 <= sample_in;
        a_l0 <= a_l;
        a_r0 <= a_r;
        m0 <= mute;
      end
      v1 <= v0;
      if (v0) begin
        p_l <= scale(d0[31:16], a_l0);
        p_r <= scale(d0[15:0], a_r0);
        q_l <= 4'(a_l0 / 6'd3);
        q_r <= 4'(a_r0 / 6'd3);
        m1 <= m0;
      end
      sample_out_valid <= v1;
      if (v1) sample_out <= m1 ? 32'd0 : {shift(p_l, q_l), shift(p_r, q_r)};
    end
endmodule

// File: tb/tb_audio_volume.sv
// tb_audio_volume: scoreboard bench for audio_volume (default build, no ramping)
module tb_audio_volume;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sample_in_valid = 1'b0;
  logic [31:0] sample_in = '0;
  logic [5:0]  lch_db = '0;
  logic [5:0]  rch_db = '0;
  logic        is_muted = 1'b0;
  logic        sample_out_valid;
  logic [31:0] sample_out;
  audio_volume dut (
    .clk(clk),
    .reset_n(reset_n),
    .sample_in_valid(sample_in_valid),
    .sample_in(sample_in),
    .lch_db(lch_db),
    .rch_db(rch_db),
    .is_muted(is_muted),
    .sample_out_valid(sample_out_valid),
    .sample_out(sample_out)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] d;
    int          t;
  } exp_t;
  exp_t        sb[$];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] last = '0;
  always @(posedge clk) cyc++;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask
  task automatic send(input logic [31:0] d, input logic [5:0] l, input logic [5:0] r, input logic m, input logic [31:0] e);
    exp_t x;
    @(negedge clk);
    sample_in_valid = 1'b1;
    sample_in = d;
    lch_db = l;
    rch_db = r;
    is_muted = m;
    x.d = e;
    x.t = cyc + 3;
    sb.push_back(x);
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      sample_in_valid = 1'b0;
      sample_in = 32'hDEAD_BEEF;
      lch_db = 6'd7;
      rch_db = 6'd9;
      is_muted = 1'b1;
    end
  endtask
  always @(negedge clk) begin
    if (reset_n) begin
      if (sample_out_valid) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_valid: got %h at cycle %0d, expected no output", sample_out, cyc);
        end else begin
          exp_t x;
          x = sb.pop_front();
          check("data", sample_out, x.d);
          check("latency", 32'(cyc), 32'(x.t));
        end
      end else check("hold", sample_out, last);
      last = sample_out;
    end
  end
  initial begin
    #3;
    check("reset_valid", {31'd0, sample_out_valid}, 32'd0);
    check("reset_data", sample_out, 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    send(32'h4000_4000, 6'd0, 6'd3, 1'b0, 32'h4000_2000);
    idle(4);
    send(32'h4000_C000, 6'd1, 6'd1, 1'b0, 32'h32D6_CD29);
    send(32'h7FFF_7FFF, 6'd43, 6'd50, 1'b0, 32'h0001_0001);
    send(32'h7FFF_8000, 6'd0, 6'd0, 1'b1, 32'h0000_0000);
    send(32'h7FFF_8000, 6'd0, 6'd0, 1'b0, 32'h7FFF_8000);
    send(32'h8000_8000, 6'd43, 6'd2, 1'b0, 32'hFFFE_AF3D);
    send(32'hFFFF_0001, 6'd1, 6'd1, 1'b0, 32'hFFFF_0000);
    send(32'h7FFF_0000, 6'd63, 6'd0, 1'b0, 32'h0001_0000);
    send(32'h1234_ABCD, 6'd2, 6'd4, 1'b0, 32'h0B7C_DE8E);
    idle(3);
    for (int i = 0; i < 8; i++)
      send(32'h4000_4000, i < 4 ? 6'd0 : 6'd3, 6'd0, 1'b0, i < 4 ? 32'h4000_4000 : 32'h2000_4000);
    idle(6);
    check("drain1", 32'(sb.size()), 32'd0);
    send(32'h5555_5555, 6'd0, 6'd0, 1'b0, 32'h5555_5555);
    send(32'h6666_6666, 6'd0, 6'd0, 1'b0, 32'h6666_6666);
    idle(1);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_valid", {31'd0, sample_out_valid}, 32'd0);
    check("rst_data", sample_out, 32'd0);
    sb.delete();
    last = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    idle(5);
    send(32'h4000_4000, 6'd3, 6'd0, 1'b0, 32'h2000_4000);
    idle(1);
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    idle(2);
    check("drain2", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/audio_volume.md
AUDIO_VOLUME -- requirements
Module: audio_volume

Interface
REQ-001 Parameters: none.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 sample_in_valid  input  1  one-cycle strobe; sample_in carries one stereo frame.
REQ-005 sample_in  input  32  [31:16] left, [15:0] right; signed two's complement.
REQ-006 lch_db  input  6  left attenuation code; value n = 2n dB attenuation; 0..43 valid.
REQ-007 rch_db  input  6  right attenuation code, same encoding.
REQ-008 is_muted  input  1  level; 1 = mute requested.
REQ-009 sample_out_valid  output  1  one-cycle strobe, one per accepted input frame.
REQ-010 sample_out  output  32  attenuated frame; same packing as sample_in.

Function
REQ-011 No backpressure; SHALL accept a frame on every cycle sample_in_valid=1, including back-to-back cycles.
REQ-012 Latency SHALL be exactly 2 cycles: valid at edge k -> sample_out_valid high for the cycle after edge k+2; order preserved.
REQ-013 Codes 44..63 SHALL be clamped to 43 before use.
REQ-014 Effective code a (per channel) SHALL be decomposed a = 3q + r, q in 0..14, r in 0..2.
REQ-015 Mantissa table (Q1.15, unsigned): r=0 -> 32768, r=1 -> 26029, r=2 -> 20675.
REQ-016 Output channel SHALL equal (sample x mantissa) arithmetically shifted right by 15+q; floor rounding (toward minus infinity); 32-bit signed product; result always fits 16 bits without saturation.
REQ-017 Stage 1 registers the product and q; stage 2 shifts and drives outputs.
REQ-018 Both channels of one frame SHALL use gain codes captured on that frame's accept edge; gain inputs changing between frames never affect a frame in flight.
REQ-019 Mute: when the mute condition (REQ-024/REQ-026) holds at accept, both channels of that frame SHALL output 0x0000.
REQ-020 sample_out SHALL hold its last value while sample_out_valid=0.

Reset
REQ-021 reset_n=0 SHALL immediately force sample_out_valid=0, sample_out=0, pipeline valid flags=0, current gain registers=43.
REQ-022 Frames in flight at reset assertion SHALL be discarded, never emitted.
REQ-023 First frame accepted after reset_n deasserts SHALL be processed normally (macro-dependent gain per REQ-024/REQ-025).

Configuration
REQ-024 VOLUME_RAMP_EN undefined: effective code = clamped input code at accept; mute condition = is_muted at accept; current gain registers unused except for reset value.
REQ-025 VOLUME_RAMP_EN defined: per-channel current code c; frame uses c as held before the accept edge; at the same edge c moves one step toward target (c+1 if c<target, c-1 if c>target, unchanged if equal).
REQ-026 With VOLUME_RAMP_EN: target = 43 while is_muted=1, else clamped input code; mute condition = is_muted=1 AND both c values already 43 before the accept edge; unmute ramps down from 43 one step per frame.
REQ-027 With VOLUME_RAMP_EN: c changes only on accepted frames, never on idle cycles.

Verification
REQ-028 Unity/6 dB: lch_db=0, rch_db=3, frame 0x4000_4000 -> output 0x4000_2000, valid exactly 2 cycles later.
REQ-029 Rounding: lch_db=rch_db=1, frame {16384, -16384} -> {13014, -13015}; lch_db=43, input 32767 -> 1; lch_db=50 gives same output as 43.
REQ-030 Throughput/consistency: 8 back-to-back frames, lch_db changed 0->3 mid-burst -> 8 consecutive valid outputs, each frame scaled by the code present on its own accept edge.
REQ-031 Mute (no macro): is_muted=1, frame 0x7FFF_8000 -> 0x0000_0000; is_muted=0 next frame -> full-scale passthrough at code 0.
REQ-032 Ramp (macro): after reset, codes 0, unmuted, 44 frames of 0x4000 -> frame 1 at code 43, frame 44 at code 0 (0x4000); then is_muted=1 -> 43 ramping frames, zeros from frame 44 onward.
REQ-033 Reset mid-burst: reset_n pulsed low with 2 frames in flight -> no sample_out_valid for those frames, sample_out=0 immediately.
